key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_debounce_cell.sv | 123 ++++++++++++
 rtl/key_debounce.sv | 73 +++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants for the five-key debouncer: key count, default timing and
// the per-key FSM state encoding.
package key_pkg;

  localparam int NUM_KEYS            = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_LONG_CYCLES     = 50000000;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRESS_DB   = 3'd1;
  localparam logic [2:0] ST_PRESSED    = 3'd2;
  localparam logic [2:0] ST_LONG       = 3'd3;
  localparam logic [2:0] ST_RELEASE_DB = 3'd4;

  // The debounced level stays asserted while a release is still being qualified.
  function automatic logic state_is_held(input logic [2:0] st);
    return (st == ST_PRESSED) || (st == ST_LONG) || (st == ST_RELEASE_DB);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchronizer, debounce/long-press FSM and its two counters.
// Press/release/long outputs are registered one-cycle pulses.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_n_i,
  output logic [2:0] state_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o
);

  localparam int CW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          from_long_q, from_long_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  assign s = ~sync2_q;

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    from_long_d = from_long_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d  = ST_PRESS_DB;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_PRESSED;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
          from_long_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d  = ST_RELEASE_DB;
          db_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d     = ST_LONG;
          long_d      = 1'b1;
          from_long_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (!s) begin
          state_d  = ST_RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      ST_RELEASE_DB: begin
        // A bounce back to pressed resumes where it left off; hold count was frozen.
        if (s) begin
          state_d = from_long_q ? ST_LONG : ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      from_long_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= key_n_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      from_long_q <= from_long_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Five-key debouncer top: one cell per key plus a registered priority encoder
// (key_valid/key_code) and a registered multi-key indicator.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                key_valid,
  output logic [2:0]          key_code,
  output logic                key_multi
);

  logic [2:0] cell_state [NUM_KEYS];
  logic       key_valid_q, key_valid_d;
  logic [2:0] key_code_q, key_code_d;
  logic       key_multi_q, key_multi_d;
  logic [2:0] held_cnt;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_cell (
      .clk_i    (sys_clk),
      .rst_i    (sys_rst),
      .key_n_i  (key[g]),
      .state_o  (cell_state[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g])
    );
    assign key_state[g] = state_is_held(cell_state[g]);
  end

  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = |key_press;
    held_cnt    = '0;
    // Descending scan so the lowest pressing index wins.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_press[i]) key_code_d = 3'(i);
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      held_cnt = held_cnt + 3'(key_state[i]);
    end
    key_multi_d = (held_cnt >= 3'd2);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 3'd0;
      key_multi_q <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_multi_q <= key_multi_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_multi = key_multi_q;

endmodule
